zigbee_pad_mux: RTL and testbench



---
 rtl/zigbee_pad_mux.sv | 125 ++++++++++++
 tb/tb_zigbee_pad_mux.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/zigbee_pad_mux.sv
// Pad-ring channel mux for the zigbee platform core: synchronised pad inputs,
// filtered channel select, strobe capture and a guarded registered output switch.
module zigbee_pad_mux #(
  parameter  int NCH         = 4,
  parameter  int IN_W        = 22,
  parameter  int OUT_W       = 18,
  parameter  int SYNC_STAGES = 2,
  parameter  int GUARD       = 3,
  localparam int SEL_W       = $clog2(NCH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [SEL_W-1:0]     pad_sel_i,
  input  logic                 pad_strobe_i,
  input  logic [IN_W-1:0]      pad_in_i,
  output logic [OUT_W-1:0]     pad_out_o,
  output logic                 pad_frame_o,
  output logic [NCH*IN_W-1:0]  core_in_o,
  output logic [NCH-1:0]       core_in_vld_o,
  input  logic [NCH*OUT_W-1:0] core_out_i
);

  typedef enum logic {
    ST_GUARD,
    ST_RUN
  } state_t;

  localparam logic [3:0]     GUARD_C = 4'(GUARD);
  localparam logic [SEL_W:0] NCH_C   = (SEL_W+1)'(NCH);

  logic [SEL_W-1:0]       sel_sync [SYNC_STAGES];
  logic [SEL_W-1:0]       sel_prev;
  logic [SYNC_STAGES-1:0] stb_sync;
  logic                   stb_dly;
  logic [IN_W-1:0]        din_sync [SYNC_STAGES];

  state_t           state;
  logic [3:0]       cnt;
  logic [SEL_W-1:0] active;

  logic [OUT_W-1:0] out_ch [NCH];
  logic [IN_W-1:0]  in_ch  [NCH];

  logic [SEL_W-1:0] cand;
  logic             commit;
  logic             rise;

  assign cand   = sel_sync[SYNC_STAGES-1];
  assign commit = (cand != active) &&
                  (cand == sel_prev) &&
                  ({1'b0, cand} < NCH_C);
  assign rise   = stb_sync[SYNC_STAGES-1] & ~stb_dly;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign out_ch[c] = core_out_i[c*OUT_W +: OUT_W];
    assign core_in_o[c*IN_W +: IN_W] = in_ch[c];
  end

  // Data and strobe share one depth so a captured word lines up with its edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sel_sync[i] <= '0;
        din_sync[i] <= '0;
      end
      stb_sync <= '0;
      stb_dly  <= 1'b0;
      sel_prev <= '0;
    end else begin
      sel_sync[0] <= pad_sel_i;
      din_sync[0] <= pad_in_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sel_sync[i] <= sel_sync[i-1];
        din_sync[i] <= din_sync[i-1];
      end
      stb_sync <= {stb_sync[SYNC_STAGES-2:0], pad_strobe_i};
      stb_dly  <= stb_sync[SYNC_STAGES-1];
      sel_prev <= cand;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_GUARD;
      cnt           <= GUARD_C;
      active        <= '0;
      pad_out_o     <= '0;
      pad_frame_o   <= 1'b0;
      core_in_vld_o <= '0;
      for (int c = 0; c < NCH; c++) begin
        in_ch[c] <= '0;
      end
    end else begin
      core_in_vld_o <= '0;
      unique case (state)
        ST_GUARD: begin
          pad_out_o   <= '0;
          pad_frame_o <= 1'b0;
          if (commit) begin
            active <= cand;
            cnt    <= GUARD_C;
          end else if (cnt == '0) begin
            state <= ST_RUN;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RUN: begin
          // The switching edge still carries the old channel; zeros follow.
          pad_out_o   <= out_ch[active];
          pad_frame_o <= 1'b1;
          if (commit) begin
            active <= cand;
            cnt    <= GUARD_C;
            state  <= ST_GUARD;
          end else if (rise) begin
            in_ch[active]         <= din_sync[SYNC_STAGES-1];
            core_in_vld_o[active] <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zigbee_pad_mux.sv
// Bench for zigbee_pad_mux: directed scenarios plus random traffic,
// every cycle compared against a sample-history reference model.
module tb_zigbee_pad_mux;

  localparam int NCH   = 4;
  localparam int IN_W  = 22;
  localparam int OUT_W = 18;
  localparam int SS    = 2;
  localparam int G     = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst  = 1'b1;
  logic [1:0]           sel  = '0;
  logic                 stb  = 1'b0;
  logic [IN_W-1:0]      din  = '0;
  logic [NCH*OUT_W-1:0] cout = '0;
  logic [OUT_W-1:0]     pout;
  logic                 frame;
  logic [NCH*IN_W-1:0]  cin;
  logic [NCH-1:0]       vld;

  logic [1:0]         sel3  = 2'd3;
  logic [3*OUT_W-1:0] cout3 = '0;
  logic [OUT_W-1:0]   pout3;
  logic               frame3;
  logic [3*IN_W-1:0]  cin3;
  logic [2:0]         vld3;

  zigbee_pad_mux #(
    .NCH(NCH), .IN_W(IN_W), .OUT_W(OUT_W),
    .SYNC_STAGES(SS), .GUARD(G)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .pad_sel_i(sel), .pad_strobe_i(stb),
    .pad_in_i(din), .pad_out_o(pout),
    .pad_frame_o(frame), .core_in_o(cin),
    .core_in_vld_o(vld), .core_out_i(cout)
  );

  zigbee_pad_mux #(
    .NCH(3), .IN_W(IN_W), .OUT_W(OUT_W),
    .SYNC_STAGES(SS), .GUARD(G)
  ) dut3 (
    .clk_i(clk), .rst_i(rst),
    .pad_sel_i(sel3), .pad_strobe_i(stb),
    .pad_in_i(din), .pad_out_o(pout3),
    .pad_frame_o(frame3), .core_in_o(cin3),
    .core_in_vld_o(vld3), .core_out_i(cout3)
  );

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int lows = 0;

  // h*[k]: value sampled k edges ago (k=0 is the current edge)
  logic [1:0]      hsel [SS+2];
  logic            hstb [SS+2];
  logic [IN_W-1:0] hdin [SS+2];
  int              quiet;
  int              act;
  logic [OUT_W-1:0] m_out;
  logic             m_frame;
  logic [IN_W-1:0]  m_in [NCH];
  logic [NCH-1:0]   m_vld;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NCH*IN_W-1:0] m_pack();
    logic [NCH*IN_W-1:0] v;
    for (int c = 0; c < NCH; c++) v[c*IN_W +: IN_W] = m_in[c];
    return v;
  endfunction

  task automatic model_edge();
    int  cand;
    int  prev;
    bit  commit;
    bit  rise;
    if (rst) begin
      for (int k = 0; k < SS+2; k++) begin
        hsel[k] = '0;
        hstb[k] = 1'b0;
        hdin[k] = '0;
      end
      quiet   = G + 1;
      act     = 0;
      m_out   = '0;
      m_frame = 1'b0;
      m_vld   = '0;
      for (int c = 0; c < NCH; c++) m_in[c] = '0;
    end else begin
      for (int k = SS+1; k > 0; k--) begin
        hsel[k] = hsel[k-1];
        hstb[k] = hstb[k-1];
        hdin[k] = hdin[k-1];
      end
      hsel[0] = sel;
      hstb[0] = stb;
      hdin[0] = din;
      cand   = int'(hsel[SS]);
      prev   = int'(hsel[SS+1]);
      commit = (cand != act) && (cand == prev) && (cand < NCH);
      rise   = hstb[SS] && !hstb[SS+1];
      m_vld  = '0;
      if (quiet > 0) begin
        m_out   = '0;
        m_frame = 1'b0;
        if (commit) begin
          act   = cand;
          quiet = G + 1;
        end else begin
          quiet--;
        end
      end else begin
        m_out   = cout[act*OUT_W +: OUT_W];
        m_frame = 1'b1;
        if (commit) begin
          act   = cand;
          quiet = G + 1;
        end else if (rise) begin
          m_in[act]  = hdin[SS];
          m_vld[act] = 1'b1;
        end
      end
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      chk("pad_out", pout, m_out);
      chk("frame", frame, m_frame);
      chk("core_in", cin, m_pack());
      chk("vld", vld, m_vld);
      if (vld != '0) pulses++;
      if (!frame) lows++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [95:0] r;
    cout  = {18'h11111, 18'h00F0F, 18'h0C3C3, 18'h2A5A5};
    cout3 = {18'h03030, 18'h01234, 18'h15555};
    @(negedge clk);
    cyc(2);
    rst = 1'b0;

    lows = 0;
    cyc(8);
    chk("s1_lows", lows, 4);
    chk("s1_out", pout, 18'h2A5A5);
    chk("s1_frame", frame, 1'b1);
    chk("n3_frame", frame3, 1'b1);
    chk("n3_out", pout3, 18'h15555);

    sel = 2'd2;
    lows = 0;
    cyc(12);
    chk("s2_lows", lows, 4);
    chk("s2_out", pout, 18'h00F0F);

    sel = 2'd1;
    cyc(12);
    din = 22'h3ABCDE;
    cyc(4);
    pulses = 0;
    stb = 1'b1;
    cyc(4);
    stb = 1'b0;
    cyc(6);
    chk("s3_pulses", pulses, 1);
    chk("s3_word", cin[43:22], 22'h3ABCDE);
    chk("s3_other", {cin[87:44], cin[21:0]}, '0);

    sel = 2'd3;
    cyc(1);
    sel = 2'd1;
    lows = 0;
    cyc(8);
    chk("s4_lows", lows, 0);
    chk("s4_out", pout, 18'h0C3C3);

    din = 22'h155AA;
    cyc(4);
    pulses = 0;
    sel = 2'd3;
    cyc(1);
    stb = 1'b1;
    cyc(1);
    stb = 1'b0;
    cyc(1);
    stb = 1'b1;
    cyc(12);
    stb = 1'b0;
    cyc(4);
    chk("s5_pulses", pulses, 0);
    chk("s5_word", cin[43:22], 22'h3ABCDE);

    lows = 0;
    sel = 2'd0;
    cyc(3);
    sel = 2'd2;
    cyc(17);
    chk("s5_lows", lows, 7);
    chk("s5_out", pout, 18'h00F0F);

    sel = 2'd1;
    cyc(5);
    rst = 1'b1;
    sel = 2'd0;
    cyc(1);
    chk("s6_out", pout, '0);
    chk("s6_frame", frame, 1'b0);
    chk("s6_cin", cin, '0);
    chk("s6_vld", vld, '0);
    rst = 1'b0;
    lows = 0;
    cyc(8);
    chk("s6_lows", lows, 4);
    chk("s6_run", pout, 18'h2A5A5);

    din = 22'h2F00D;
    cyc(4);
    pulses = 0;
    stb = 1'b1;
    cyc(1);
    rst = 1'b1;
    stb = 1'b0;
    cyc(1);
    rst = 1'b0;
    lows = 0;
    cyc(10);
    chk("s6_pulses", pulses, 0);
    chk("s6_lows2", lows, 4);
    chk("s6_cin2", cin, '0);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 15) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) stb = ~stb;
      r = {$urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) din = r[IN_W-1:0];
      if ($urandom_range(0, 1) == 0) cout = r[NCH*OUT_W-1:0];
      cyc(1);
    end

    rst = 1'b0;
    sel3 = 2'd2;
    cyc(12);
    chk("n3_sel_out", pout3, 18'h03030);
    chk("n3_sel_frame", frame3, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
